// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the shared-adder arbiter block.
package adder_share_arbiter_pkg;

   // Number of requesters and operand width; both fixed in this revision.
   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 16;

   // Controller states: waiting for a request, adding, holding the result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Requester index.
   typedef logic [1:0] req_id_t;

   // Converts a one-hot grant vector to the index of its set bit.
   function automatic req_id_t onehot_to_id(input logic [NUM_REQ-1:0] oh);
      req_id_t id;
      id = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) id = req_id_t'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the arbiter.
//
// Handshake rule, used on both sides: a transfer happens in a cycle only when
// valid and ready are both high at the rising clock edge. Request side: the
// arbiter raises reqReady[i] (one-hot) for the chosen requester i while
// reqValid[i] is high. Response side: respValid stays high and respSum,
// respCarryOut and respId stay unchanged until respReady is seen high.
interface adder_share_arbiter_if;
   import adder_share_arbiter_pkg::*;

   logic [NUM_REQ-1:0]       reqValid;
   logic [NUM_REQ-1:0]       reqReady;
   logic [NUM_REQ*WIDTH-1:0] reqA;
   logic [NUM_REQ*WIDTH-1:0] reqB;
   logic [NUM_REQ-1:0]       reqCarryIn;
   logic                     respValid;
   logic                     respReady;
   logic [WIDTH-1:0]         respSum;
   logic                     respCarryOut;
   req_id_t                  respId;
   logic                     busy;

   // Requester/consumer side.
   modport master (
      output reqValid, reqA, reqB, reqCarryIn, respReady,
      input  reqReady, respValid, respSum, respCarryOut, respId, busy
   );

   // Arbiter side.
   modport slave (
      input  reqValid, reqA, reqB, reqCarryIn, respReady,
      output reqReady, respValid, respSum, respCarryOut, respId, busy
   );

endinterface

// File: rtl/adder_share_arbiter_fa16.sv
// 16-bit ripple-carry adder built from single-bit full adders.
module FullAdderX16
   import adder_share_arbiter_pkg::*;
(
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin_i;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
   end

   assign cout_o = carry[WIDTH];

endmodule

// File: rtl/adder_share_arbiter_rr.sv
// Four-way round-robin grant: first valid requester at or after ptr, wrapping.
module rr_arbiter4
   import adder_share_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  req_id_t            ptr_i,
   output logic [NUM_REQ-1:0] grant_o
);

   req_id_t idx;
   logic    found;

   // Scan ptr, ptr+1, ... (2-bit wrap) and grant the first valid requester.
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr_i + req_id_t'(k);
         if (!found && req_valid_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Four requesters share one 16-bit adder; one add in flight at a time.
// IDLE grants round-robin and captures operands, CALC runs the adder for one
// cycle into the result registers, RESP holds the result until accepted.
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstN,
   adder_share_arbiter_if.slave  bus,
   output state_e                dbg_state_o
);

   state_e           state_q, state_d;
   req_id_t          ptr_q, ptr_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cin_q, cin_d;
   req_id_t          id_q, id_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [NUM_REQ-1:0] grant;
   req_id_t            grant_id;
   logic [WIDTH-1:0]   op_a [NUM_REQ];
   logic [WIDTH-1:0]   op_b [NUM_REQ];
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;

   // Split the packed operand buses into per-requester words.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_a[i] = bus.reqA[i*WIDTH +: WIDTH];
      assign op_b[i] = bus.reqB[i*WIDTH +: WIDTH];
   end

   rr_arbiter4 u_arb (
      .req_valid_i (bus.reqValid),
      .ptr_i       (ptr_q),
      .grant_o     (grant)
   );

   assign grant_id = onehot_to_id(grant);

   // The only adder in the datapath; it always sees the captured operands.
   FullAdderX16 u_add (
      .a_i    (a_q),
      .b_i    (b_q),
      .cin_i  (cin_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // State, pointer, captured request and result registers.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         id_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         id_q    <= id_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // Next state, captures and handshake outputs.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      a_d           = a_q;
      b_d           = b_q;
      cin_d         = cin_q;
      id_d          = id_q;
      sum_d         = sum_q;
      cout_d        = cout_q;
      bus.reqReady  = '0;
      bus.respValid = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Grant is combinational; masked while reset is held.
            bus.reqReady = rstN ? grant : '0;
            if (|grant) begin
               a_d     = op_a[grant_id];
               b_d     = op_b[grant_id];
               cin_d   = bus.reqCarryIn[grant_id];
               id_d    = grant_id;
               ptr_d   = grant_id + 2'd1;
               state_d = CALC;
            end
         end
         CALC: begin
            sum_d   = add_sum;
            cout_d  = add_cout;
            state_d = RESP;
         end
         RESP: begin
            bus.respValid = 1'b1;
            if (bus.respReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.respSum      = sum_q;
   assign bus.respCarryOut = cout_q;
   assign bus.respId       = id_q;
   assign bus.busy         = (state_q != IDLE);
   assign dbg_state_o      = state_q;

endmodule

// File: doc/adder_share_arbiter.md
ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, 4, number of requesters (fixed at 4 in this revision); WIDTH, 16, operand width (fixed at 16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstN  input  1  reset, asynchronous assert, active-low.
REQ-004 reqValid  input  4  requester i has an add pending (bit i).
REQ-005 reqReady  output  4  one-hot grant; transfer on reqValid[i] & reqReady[i].
REQ-006 reqA  input  64  operand A, requester i on bits [16i+15:16i].
REQ-007 reqB  input  64  operand B, same packing as reqA.
REQ-008 reqCarryIn  input  4  carry-in per requester.
REQ-009 respValid  output  1  result held for requester respId.
REQ-010 respReady  input  1  consumer accepts result when respValid & respReady.
REQ-011 respSum  output  16  registered sum.
REQ-012 respCarryOut  output  1  registered carry-out.
REQ-013 respId  output  2  index of requester that owns the result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CALC, RESP; one transaction outstanding at most.
REQ-016 IDLE: if any reqValid, reqReady SHALL be one-hot to the round-robin winner (combinational from reqValid and pointer); else reqReady = 0.
REQ-017 Round-robin: search order starts at pointer ptr, wrapping 3->0; on grant to i, ptr <= (i+1) mod 4.
REQ-018 On grant, operands, carryIn and id SHALL be captured and state -> CALC; reqReady SHALL be 0 in CALC and RESP.
REQ-019 CALC (exactly 1 cycle): captured operands drive the shared 16-bit adder; {respCarryOut, respSum} <= A + B + carryIn (17-bit, no truncation of carry); state -> RESP.
REQ-020 RESP: respValid = 1 and respSum/respCarryOut/respId SHALL remain stable until respReady sampled high; then respValid -> 0, state -> IDLE.
REQ-021 Latency: grant in cycle N -> respValid high from cycle N+2; minimum throughput one add per 3 cycles.
REQ-022 reqValid deasserting after grant SHALL NOT affect the in-flight transaction; reqValid changes during CALC/RESP are ignored.
REQ-023 Overflow: 0xFFFF + 0x0001 + 0 SHALL give respSum 0x0000, respCarryOut 1; no saturation.
REQ-024 respReady held high permanently SHALL still give one RESP cycle per transaction.

Reset
REQ-025 While rstN = 0: state IDLE, ptr 0, reqReady 0, respValid 0, respSum 0x0000, respCarryOut 0, respId 0, busy 0.
REQ-026 Reset asserted in CALC or RESP SHALL discard the transaction with no respValid pulse afterwards.
REQ-027 First grant after reset release SHALL follow ptr = 0 priority.

Structure
REQ-028 Shared package SHALL hold NUM_REQ, WIDTH, the FSM state enum (IDLE/CALC/RESP) and the requester-id type.
REQ-029 Datapath SHALL instantiate the existing 16-bit ripple-carry adder FullAdderX16 once; no other adder inferred.
REQ-030 Grant logic SHALL be a sub-module rr_arbiter4 (inputs reqValid, ptr; output one-hot grant); FSM and registers stay in the top.

Verification
REQ-031 Single req: reqValid=0001, A=0x1234, B=0x0101, cin=0 -> reqReady=0001 at N, respValid at N+2, respSum 0x1335, carryOut 0, respId 0.
REQ-032 Overflow: requester 2, A=0xFFFF, B=0x0001, cin=1 -> respSum 0x0001, respCarryOut 1, respId 2.
REQ-033 Fairness: reqValid=1111 held, respReady=1 -> grant order 0,1,2,3,0 with ids matching; each requester exactly once per 4 results.
REQ-034 Backpressure: respReady=0 for 5 cycles in RESP -> respValid and outputs stable all 5 cycles, no new reqReady; release -> IDLE next cycle.
REQ-035 Reset mid-op: rstN low during CALC -> all outputs at reset values immediately; after release, no stale respValid, next grant uses ptr 0.
REQ-036 Withdrawal: requester 1 drops reqValid in CALC -> result still delivered with respId 1.
